// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared UART definitions: receive FSM states, frame width, default rates and divisor helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int DATA_BITS    = 8;
  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 115200;

  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
// Oversample tick generator: one-cycle tick every DIV clocks, held at phase 0 while restart=1.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || restart) cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx_frontend.sv
`timescale 1ns/1ps
// 8N1 receive front end: 2-FF sync, oversampled 3-sample majority per bit, one-byte
// holding register on a valid/ready interface with framing-error and overrun pulses.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD       = DEF_BAUD,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int M   = OVERSAMPLE / 2;
  localparam logic [SW-1:0] S_LO  = SW'(M - 1);
  localparam logic [SW-1:0] S_MID = SW'(M);
  localparam logic [SW-1:0] S_DEC = SW'(M + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);

  logic                 rx_meta, rxs;
  rx_state_e            state;
  logic                 restart, tick, maj;
  logic [SW-1:0]        s_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [1:0]           smp;
  logic [DATA_BITS-1:0] shreg;

  always_ff @(posedge clk) begin
    if (reset) {rxs, rx_meta} <= 2'b11;
    else       {rxs, rx_meta} <= {rx_meta, uart_rx};
  end

  // Tick phase is pinned to 0 in IDLE so bit timing starts at the detected edge.
  assign restart = (state == ST_IDLE);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  assign maj = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      s_cnt     <= '0;
      bit_cnt   <= '0;
      smp       <= 2'b11;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        ST_IDLE: if (!rxs) begin
          state   <= ST_START;
          busy    <= 1'b1;
          s_cnt   <= '0;
          bit_cnt <= '0;
        end
        default: if (tick) begin
          s_cnt <= (s_cnt == S_END) ? '0 : s_cnt + SW'(1);
          if (s_cnt == S_LO)  smp[0] <= rxs;
          if (s_cnt == S_MID) smp[1] <= rxs;
          case (state)
            ST_START: begin
              if (s_cnt == S_DEC && maj) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else if (s_cnt == S_END) begin
                state <= ST_DATA;
              end
            end
            ST_DATA: begin
              if (s_cnt == S_DEC) shreg <= {maj, shreg[DATA_BITS-1:1]};
              if (s_cnt == S_END) begin
                if (bit_cnt == B_END) state <= ST_STOP;
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
            ST_STOP: begin
              // Decide mid stop bit so a following start edge is seen from IDLE.
              if (s_cnt == S_DEC) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                if (!maj)                     frame_err <= 1'b1;
                else if (rx_valid && !rx_ready) overrun <= 1'b1;
                else begin
                  rx_data  <= shreg;
                  rx_valid <= 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
`timescale 1ns/1ps
// Bench for uart_rx_frontend: line driver plus holding-register model feed expectation
// queues; an independent monitor pops them on accepted bytes and error pulses.
module tb_uart_rx_frontend;
  localparam int BIT_NS = 8681;
  localparam int P_FERR = 1;
  localparam int P_OVR  = 2;

  logic       clk = 1'b0, reset = 1'b1, uart_rx = 1'b1, rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  int         n_chk = 0, n_fail = 0;
  logic [7:0] exp_bytes[$];
  int         exp_pulses[$];
  bit         held = 1'b0;

  uart_rx_frontend dut (
    .clk      (clk),
    .reset    (reset),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_ev(input int kind);
    int e;
    if (exp_pulses.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL unexpected_pulse: got kind %0d, required none", kind);
    end else begin
      e = exp_pulses.pop_front();
      check("pulse_kind", kind, e);
    end
  endtask

  // Monitor: every negedge with valid&ready is one accepted byte; every high
  // error-pulse cycle is one event, so a stretched pulse shows up as an extra event.
  always @(negedge clk) begin
    logic [7:0] eb;
    if (!reset) begin
      if (rx_valid && rx_ready) begin
        if (exp_bytes.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h, required no delivery", rx_data);
        end else begin
          eb = exp_bytes.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, eb});
        end
      end
      if (frame_err) pulse_ev(P_FERR);
      if (overrun)   pulse_ev(P_OVR);
    end
  end

  task automatic idle(input int bits);
    uart_rx = 1'b1;
    #(bits * BIT_NS);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input int per);
    uart_rx = 1'b0;
    #(per);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      #(per);
    end
    uart_rx = stop_bit;
    #(per);
    uart_rx = 1'b1;
  endtask

  // Reference model: a frame either errors, overruns a held byte, or lands in the register.
  task automatic send_exp(input logic [7:0] d, input bit stop_ok, input int per);
    if (!stop_ok)  exp_pulses.push_back(P_FERR);
    else if (held) exp_pulses.push_back(P_OVR);
    else begin
      exp_bytes.push_back(d);
      held = !rx_ready;
    end
    send_frame(d, stop_ok, per);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_rx_data"},   {24'd0, rx_data}, 32'd0);
    check({tag, "_rx_valid"},  rx_valid,  0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_overrun"},   overrun,   0);
    check({tag, "_busy"},      busy,      0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    int per;
    repeat (5) @(posedge clk);
    #1;
    check_cleared("reset");
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // single byte
    send_exp(8'h41, 1'b1, BIT_NS);
    idle(1);
    check("busy_after_frame", busy, 0);

    // back-to-back frames
    send_exp(8'h41, 1'b1, BIT_NS);
    send_exp(8'h42, 1'b1, BIT_NS);
    idle(1);

    // short glitch on idle line
    uart_rx = 1'b0;
    #1000;
    uart_rx = 1'b1;
    #100;
    check("busy_on_glitch", busy, 1);
    #(BIT_NS);
    check("busy_after_glitch", busy, 0);
    check("valid_after_glitch", rx_valid, 0);

    // bad stop bit
    send_exp(8'h55, 1'b0, BIT_NS);
    idle(2);
    check("valid_after_ferr", rx_valid, 0);
    check("busy_after_ferr", busy, 0);

    // consumer stalled: second byte overruns
    @(posedge clk); #1 rx_ready = 1'b0;
    send_exp(8'h41, 1'b1, BIT_NS);
    send_exp(8'h42, 1'b1, BIT_NS);
    idle(1);
    check("held_valid", rx_valid, 1);
    check("held_data", {24'd0, rx_data}, 32'h41);
    @(posedge clk); #1 rx_ready = 1'b1;
    held = 1'b0;
    @(posedge clk); #1;
    check("valid_drop_after_accept", rx_valid, 0);

    // reset mid-frame, held until the abandoned frame is over
    fork
      send_frame(8'hA5, 1'b1, BIT_NS);
      begin
        #(BIT_NS * 4 + BIT_NS / 2);
        @(posedge clk); #1;
        check("busy_mid_frame", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_cleared("midreset");
      end
    join
    idle(1);
    reset = 1'b0;
    held  = 1'b0;
    repeat (5) @(posedge clk);

    // nominal and +/-3% line rate
    send_exp(8'h3C, 1'b1, BIT_NS);
    idle(1);
    send_exp(8'h3C, 1'b1, BIT_NS + (BIT_NS * 3) / 100);
    idle(1);
    send_exp(8'h3C, 1'b1, BIT_NS - (BIT_NS * 3) / 100);
    idle(1);

    // random bytes, rates within +/-2%, occasional bad stop bit
    for (int k = 0; k < 3; k++) begin
      d   = 8'($urandom);
      per = BIT_NS - 173 + int'($urandom_range(0, 346));
      send_exp(d, $urandom_range(0, 3) != 0, per);
      idle(int'($urandom_range(1, 2)));
    end

    repeat (100) @(posedge clk);
    check("bytes_outstanding", exp_bytes.size(), 0);
    check("pulses_outstanding", exp_pulses.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
